button_press_classifier: RTL and testbench

Classifies each debounced button press into a short press, a long press or a double press, emitting one single-cycle pulse per recognised gesture. Sits directly downstream of the debounce stage, taking its filtered `db_level`, and drives the game-control FSM. Each physical button gets its own instance.

---
 rtl/button_pkg.sv | 30 +++
 rtl/button_press_classifier_level_edge.sv | 38 +++
 rtl/button_press_classifier.sv | 198 +++++++++++++++++++
 tb/tb_button_press_classifier.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button gesture classifier. The game-control FSM
// imports this package as well, so that it can decode the classifier's `state`
// output with the same names.
//
// Contents:
//   btn_state_e  - 3-bit gesture FSM encoding (ST_IDLE .. ST_SECOND_PRESSED)
//   STATE_W      - width of the encoded state
//   ms_to_cycles - converts a duration in milliseconds to clock cycles
// -----------------------------------------------------------------------------
package button_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } btn_state_e;

  // The divide comes first so that a 50 MHz clock with multi-second
  // durations still fits comfortably in a 32-bit int.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_press_classifier_level_edge.sv
// -----------------------------------------------------------------------------
// level_edge
// Registers the debounced button level and flags its transitions. The edge
// flags compare the live input against the registered copy, so a change on
// `d` is acted on by the edge that samples it.
//
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous reset, active low
//   d     in  debounced level, 1 = pressed
//   rise  out d is 1 and was 0 on the previous cycle
//   fall  out d is 0 and was 1 on the previous cycle
// -----------------------------------------------------------------------------
module level_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic lvl_q;
  logic lvl_d;

  assign lvl_d = d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign rise = d & ~lvl_q;
  assign fall = ~d & lvl_q;

endmodule

// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
// Turns the debounced level of one button into gesture pulses: short press,
// long press or double press. Exactly one single-cycle pulse is emitted per
// recognised gesture. A short press is only reported once the double-press
// window has expired without a second press.
//
// Parameters:
//   CLK_HZ    system clock frequency in Hz
//   LONG_MS   hold time that makes a press long
//   DOUBLE_MS window after a release in which a second press counts as double
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   db_level     in   debounced button level, 1 = pressed
//   enable       in   0 forces IDLE and suppresses every pulse
//   short_press  out  one-cycle pulse, single short press recognised
//   long_press   out  one-cycle pulse, hold reached the long threshold
//   double_press out  one-cycle pulse, second press released inside window
//   state        out  current gesture state (debug / LED)
//
// State table:
//   state             | meaning
//   ------------------+------------------------------------------------------
//   ST_IDLE           | waiting for a press
//   ST_PRESSED        | first press held, timing towards the long threshold
//   ST_LONG_HELD      | long press already reported, waiting for the release
//   ST_WAIT_SECOND    | first press released, double-press window running
//   ST_SECOND_PRESSED | second press held, released -> double, held -> long
// -----------------------------------------------------------------------------
module button_press_classifier
  import button_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int LONG_MS   = 5000,
  parameter int DOUBLE_MS = 300
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               db_level,
  input  logic               enable,
  output logic               short_press,
  output logic               long_press,
  output logic               double_press,
  output logic [STATE_W-1:0] state
);

  localparam int LONG_CYC   = ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int DOUBLE_CYC = ms_to_cycles(CLK_HZ, DOUBLE_MS);
  localparam int CNT_W      = $clog2(LONG_CYC);

  // Terminal counts: the decision is taken while cnt holds TC and lands in
  // the output registers on the next edge, so the pulse appears exactly
  // LONG_CYC / DOUBLE_CYC edges after the state was entered.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DOUBLE_TC = CNT_W'(DOUBLE_CYC - 1);

  if (!(LONG_CYC > DOUBLE_CYC && DOUBLE_CYC >= 2)) begin : g_param_check
    $error("button_press_classifier: need LONG_CYC > DOUBLE_CYC >= 2");
  end

  // ---------------------------------------------------------------------------
  // Level register and edge flags
  // ---------------------------------------------------------------------------
  logic rise;
  logic fall;

  level_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (db_level),
    .rise  (rise),
    .fall  (fall)
  );

  // ---------------------------------------------------------------------------
  // State, counter and pulse registers
  // ---------------------------------------------------------------------------
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and pulse decisions
  // ---------------------------------------------------------------------------
  logic timed_state;

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESSED;
        end
      end

      // A release on the threshold cycle is tested first, so it wins over
      // the long press.
      ST_PRESSED: begin
        if (fall) begin
          state_d = ST_WAIT_SECOND;
        end else if (db_level && (cnt_q == LONG_TC)) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end
      end

      ST_LONG_HELD: begin
        if (fall) begin
          state_d = ST_IDLE;
        end
      end

      // A press on the timeout cycle is tested first: it becomes the second
      // press of a double and the short press is never reported.
      ST_WAIT_SECOND: begin
        if (rise) begin
          state_d = ST_SECOND_PRESSED;
        end else if (cnt_q == DOUBLE_TC) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end

      // Holding the second press long enough turns the gesture into a long
      // press; the pending double press is dropped.
      ST_SECOND_PRESSED: begin
        if (fall) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end else if (db_level && (cnt_q == LONG_TC)) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disable overrides everything decided above, including a pulse that
    // would have fired this cycle. The level register keeps tracking, so a
    // button still held when enable returns produces no rise.
    if (!enable) begin
      state_d  = ST_IDLE;
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;
    end
  end

  // Only the three timed states run the counter. Every one of them leaves on
  // or before its terminal count, so the counter cannot wrap; the untimed
  // states park it at zero.
  assign timed_state = (state_q == ST_PRESSED)     ||
                       (state_q == ST_WAIT_SECOND) ||
                       (state_q == ST_SECOND_PRESSED);

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && timed_state) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign state        = state_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_button_press_classifier
// Drives inputs on the falling edge and checks outputs on the next falling
// edge. A timestamp-based reference model predicts the state and pulses for
// every cycle; a segment table adds hand-derived expectations per gesture,
// and a few hand-written sequences cover latency and reset corner cases.
// Bench timing: 1000 Hz clock (1 cycle/ms), long = 20 cycles, double = 8.
// -----------------------------------------------------------------------------
module tb_button_press_classifier;

  localparam int LONG_CYC   = 20;
  localparam int DOUBLE_CYC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       db_level;
  logic       enable;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic [2:0] state;

  button_press_classifier #(
    .CLK_HZ    (1000),
    .LONG_MS   (20),
    .DOUBLE_MS (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .db_level     (db_level),
    .enable       (enable),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Stages use the debug numbering of the state output;
  // time is tracked as the index of the edge that entered the stage, and
  // the pulse decisions are made from "edges elapsed since entry".
  // ---------------------------------------------------------------------------
  int         m_edge  = 0;
  int         m_entry = 0;
  int         m_stage = 0;
  logic       m_lvl   = 1'b0;
  logic [5:0] m_exp   = '0;  // {state[2:0], short, long, double}

  task automatic model_reset();
    m_lvl   = 1'b0;
    m_stage = 0;
    m_entry = m_edge;
    m_exp   = '0;
  endtask

  task automatic model_edge(input logic db, input logic en);
    logic r, f, ps, pl, pd;
    int   elapsed, nxt;
    r  = db && !m_lvl;
    f  = !db && m_lvl;
    m_lvl = db;
    m_edge++;
    elapsed = m_edge - m_entry;
    nxt = m_stage;
    ps = 1'b0; pl = 1'b0; pd = 1'b0;
    case (m_stage)
      0: if (r) nxt = 1;
      1: if (f) nxt = 3;
         else if (elapsed == LONG_CYC) begin nxt = 2; pl = 1'b1; end
      2: if (f) nxt = 0;
      3: if (r) nxt = 4;
         else if (elapsed == DOUBLE_CYC) begin nxt = 0; ps = 1'b1; end
      4: if (f) begin nxt = 0; pd = 1'b1; end
         else if (elapsed == LONG_CYC) begin nxt = 2; pl = 1'b1; end
      default: nxt = 0;
    endcase
    if (!en) begin
      nxt = 0; ps = 1'b0; pl = 1'b0; pd = 1'b0;
    end
    if (nxt != m_stage) m_entry = m_edge;
    m_stage = nxt;
    m_exp   = {3'(nxt), ps, pl, pd};
  endtask

  // ---------------------------------------------------------------------------
  // One clock cycle: drive, advance the model, sample at the next negedge.
  // ---------------------------------------------------------------------------
  int seg_s, seg_l, seg_d;

  task automatic tick(input logic db, input logic en, input string tag);
    db_level = db;
    enable   = en;
    model_edge(db, en);
    @(negedge clk);
    check({tag, "_model"}, {29'd0, state, short_press, long_press, double_press}, {26'd0, m_exp});
    check({tag, "_excl"}, {31'd0, $countones({short_press, long_press, double_press}) <= 1}, 32'd1);
    seg_s += int'(short_press);
    seg_l += int'(long_press);
    seg_d += int'(double_press);
  endtask

  // ---------------------------------------------------------------------------
  // Segment table: hold {db, enable} for len cycles, then expect a final
  // state and the number of each pulse seen during the segment.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       db;
    logic       en;
    int         len;
    logic [2:0] st;
    int         ns;
    int         nl;
    int         nd;
  } seg_t;

  seg_t segs[$];

  function automatic seg_t mk(input logic db, input logic en, input int len,
                              input logic [2:0] st, input int ns, input int nl, input int nd);
    seg_t s;
    s.db = db; s.en = en; s.len = len; s.st = st; s.ns = ns; s.nl = nl; s.nd = nd;
    return s;
  endfunction

  int   bl[6] = '{7, 8, 9, 19, 20, 21};
  int   k;
  logic found;
  logic rlvl;
  int   rlen;
  logic ren;

  initial begin
    // short press
    segs.push_back(mk(1, 1, 5,  3'd1, 0, 0, 0));
    segs.push_back(mk(0, 1, 12, 3'd0, 1, 0, 0));
    // long press
    segs.push_back(mk(1, 1, 30, 3'd2, 0, 1, 0));
    segs.push_back(mk(0, 1, 12, 3'd0, 0, 0, 0));
    // double press
    segs.push_back(mk(1, 1, 3,  3'd1, 0, 0, 0));
    segs.push_back(mk(0, 1, 4,  3'd3, 0, 0, 0));
    segs.push_back(mk(1, 1, 3,  3'd4, 0, 0, 0));
    segs.push_back(mk(0, 1, 3,  3'd0, 0, 0, 1));
    segs.push_back(mk(0, 1, 10, 3'd0, 0, 0, 0));
    // release sampled while cnt = 19: no long, short 8 edges later
    segs.push_back(mk(1, 1, 20, 3'd1, 0, 0, 0));
    segs.push_back(mk(0, 1, 1,  3'd3, 0, 0, 0));
    segs.push_back(mk(0, 1, 8,  3'd0, 1, 0, 0));
    segs.push_back(mk(0, 1, 4,  3'd0, 0, 0, 0));
    // second press sampled while cnt = 7 of the window
    segs.push_back(mk(1, 1, 3,  3'd1, 0, 0, 0));
    segs.push_back(mk(0, 1, 8,  3'd3, 0, 0, 0));
    segs.push_back(mk(1, 1, 2,  3'd4, 0, 0, 0));
    segs.push_back(mk(0, 1, 10, 3'd0, 0, 0, 1));
    // enable dropped at cnt = 10, re-enabled while held
    segs.push_back(mk(1, 1, 11, 3'd1, 0, 0, 0));
    segs.push_back(mk(1, 0, 5,  3'd0, 0, 0, 0));
    segs.push_back(mk(1, 1, 25, 3'd0, 0, 0, 0));
    segs.push_back(mk(0, 1, 3,  3'd0, 0, 0, 0));
    segs.push_back(mk(1, 1, 2,  3'd1, 0, 0, 0));
    segs.push_back(mk(0, 1, 12, 3'd0, 1, 0, 0));
    // enable low on the cycle the short press would fire
    segs.push_back(mk(1, 1, 2,  3'd1, 0, 0, 0));
    segs.push_back(mk(0, 1, 8,  3'd3, 0, 0, 0));
    segs.push_back(mk(0, 0, 1,  3'd0, 0, 0, 0));
    segs.push_back(mk(0, 1, 10, 3'd0, 0, 0, 0));
    // second press held long: long wins, double discarded
    segs.push_back(mk(1, 1, 2,  3'd1, 0, 0, 0));
    segs.push_back(mk(0, 1, 2,  3'd3, 0, 0, 0));
    segs.push_back(mk(1, 1, 25, 3'd2, 0, 1, 0));
    segs.push_back(mk(0, 1, 3,  3'd0, 0, 0, 0));

    // reset state
    reset    = 1'b0;
    db_level = 1'b0;
    enable   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", {29'd0, state, short_press, long_press, double_press}, 32'd0);
    reset  = 1'b1;
    enable = 1'b1;

    // table
    for (int i = 0; i < segs.size(); i++) begin
      seg_s = 0; seg_l = 0; seg_d = 0;
      for (int c = 0; c < segs[i].len; c++) tick(segs[i].db, segs[i].en, "table");
      check($sformatf("seg%0d_state", i), {29'd0, state}, {29'd0, segs[i].st});
      check($sformatf("seg%0d_short", i), seg_s, segs[i].ns);
      check($sformatf("seg%0d_long", i), seg_l, segs[i].nl);
      check($sformatf("seg%0d_double", i), seg_d, segs[i].nd);
    end

    // short press latency from the WAIT_SECOND entry edge
    repeat (5) tick(1, 1, "lat_short");
    tick(0, 1, "lat_short");
    k = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick(0, 1, "lat_short");
      if (short_press) begin found = 1'b1; k = i; end
    end
    check("short_latency", k, DOUBLE_CYC);

    // long press latency from the PRESSED entry edge
    tick(1, 1, "lat_long");
    k = 0; found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      tick(1, 1, "lat_long");
      if (long_press) begin found = 1'b1; k = i; end
    end
    check("long_latency", k, LONG_CYC);
    repeat (5) tick(1, 1, "lat_long");
    check("long_held_state", {29'd0, state}, 32'd2);
    repeat (3) tick(0, 1, "lat_long");

    // reset while a double_press pulse is high clears it immediately
    repeat (3) tick(1, 1, "rst_pulse");
    repeat (3) tick(0, 1, "rst_pulse");
    repeat (2) tick(1, 1, "rst_pulse");
    tick(0, 1, "rst_pulse");
    check("double_before_reset", {31'd0, double_press}, 32'd1);
    #2 reset = 1'b0;
    #1 check("reset_async_pulse", {29'd0, state, short_press, long_press, double_press}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) tick(0, 1, "after_reset1");

    // reset in the middle of the double-press window aborts the gesture
    repeat (3) tick(1, 1, "rst_wait");
    repeat (3) tick(0, 1, "rst_wait");
    check("wait_before_reset", {29'd0, state}, 32'd3);
    #2 reset = 1'b0;
    #1 check("reset_async_wait", {29'd0, state, short_press, long_press, double_press}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    seg_s = 0; seg_l = 0; seg_d = 0;
    repeat (12) tick(0, 1, "after_reset2");
    check("no_pulse_after_reset", seg_s + seg_l + seg_d, 0);

    // randomized gestures against the model
    rlvl = 1'b0;
    for (int s = 0; s < 160; s++) begin
      rlvl = ~rlvl;
      case ($urandom_range(0, 3))
        0:       rlen = $urandom_range(1, 4);
        1:       rlen = $urandom_range(5, 12);
        2:       rlen = bl[$urandom_range(0, 5)];
        default: rlen = $urandom_range(13, 30);
      endcase
      ren = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < rlen; c++) tick(rlvl, ren, "random");
    end
    repeat (30) tick(0, 1, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
